ptr_local_ni: RTL and testbench
===============================

PTR_LOCAL_NI -- requirements
Module: ptr_local_ni

Interface
REQ-001 Parameter DATA_WIDTH, default 128, SHALL set the payload width.
REQ-002 Parameter NODE_NUM, default 128, SHALL set the ring node count; DEST_W = $clog2(NODE_NUM).
REQ-003 Parameter FIFO_DEPTH, default 4 (power of two, >=2), SHALL set the depth of each direction's FIFO.
REQ-004 Port list (name direction width meaning) SHALL be:
 clk  in  1  single clock; all logic on posedge
 rst  in  1  synchronous, active-high reset
 txVld  in  1  host flit offered for injection
 txRdy  out  1  TX FIFO can accept (not full)
 txDat  in  DATA_WIDTH  host payload
 txDest  in  DEST_W  hop count to destination
 l2rWr  out  1  flit presented to router local port
 l2rRdy  in  1  router accepts flit this cycle
 l2rDat  out  DATA_WIDTH  flit payload to router
 destCnt  out  DEST_W  hop count to router
 r2lVld  in  1  router has a flit for this node
 r2lRd  out  1  NI consumes router flit this cycle
 r2lDat  in  DATA_WIDTH  router payload
 rxVld  out  1  RX FIFO not empty
 rxRdy  in  1  host pops RX head
 rxDat  out  DATA_WIDTH  RX FIFO head
 dropCnt  out  16  flits dropped for txDest==0

Function
REQ-005 Host write SHALL occur when txVld&&txRdy; txRdy = TX FIFO not full, combinational from FIFO count.
REQ-006 A write with txDest==0 SHALL NOT enter the FIFO; dropCnt SHALL increment, saturating at 16'hFFFF.
REQ-007 TX injector SHALL be a 2-state FSM: TX_IDLE, TX_SEND.
REQ-008 TX_IDLE -> TX_SEND when TX FIFO non-empty; head is popped into output registers l2rDat/destCnt and l2rWr set to 1 on the same edge.
REQ-009 In TX_SEND, l2rWr/l2rDat/destCnt SHALL stay stable until a cycle with l2rRdy=1 (transfer).
REQ-010 On transfer: if FIFO non-empty, pop next head and stay TX_SEND (back-to-back, 1 flit/cycle); else l2rWr<=0, go TX_IDLE.
REQ-011 Host-write to l2rWr latency SHALL be 2 cycles from an empty, idle NI.
REQ-012 r2lRd SHALL be combinational: r2lVld && RX FIFO not full; r2lDat is written to RX FIFO on that edge.
REQ-013 RX FIFO full SHALL hold r2lRd=0 (backpressure to router); no flit lost.
REQ-014 rxDat SHALL be RX FIFO head (first-word fall-through); pop on rxVld&&rxRdy.
REQ-015 Simultaneous push and pop on a full FIFO SHALL be allowed on RX only when pop frees space the same cycle is NOT assumed: full blocks push regardless of pop.
REQ-016 Simultaneous push and pop on a non-full, non-empty FIFO SHALL keep count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-017 FIFO ordering SHALL be strict FIFO in both directions.

Reset
REQ-018 rst sampled high SHALL clear FIFO pointers/counts, FSM to TX_IDLE, l2rWr=0, l2rDat=0, destCnt=0, dropCnt=0 on the next edge.
REQ-019 Reset mid-TX_SEND SHALL discard the in-flight flit and FIFO contents; txRdy=1, rxVld=0, r2lRd=r2lVld on the cycle after reset.

Structure
REQ-020 Package ptr_noc_pkg SHALL hold DATA_WIDTH/NODE_NUM defaults, DEST_W, and the tx_state_e enum.
REQ-021 Both FIFOs SHALL be instances of one sub-module ptr_sync_fifo (params WIDTH, DEPTH; ports push, pop, full, empty, dout).

Verification
REQ-022 Push 3 flits (dest 1,2,3, dat 'hA,'hB,'hC) with l2rRdy=1 -> l2rWr high 3 consecutive cycles starting cycle 2, order A,B,C.
REQ-023 l2rRdy=0 for 5 cycles with one flit queued -> l2rWr, l2rDat, destCnt stable all 5 cycles; single transfer when l2rRdy=1.
REQ-024 Fill TX FIFO (4 flits + 1 in output register), l2rRdy=0 -> txRdy=0; one transfer -> txRdy=1 next cycle.
REQ-025 r2lVld=1 for 6 flits, rxRdy=0 -> r2lRd high 4 cycles then 0; drain with rxRdy=1 -> 6 flits in order.
REQ-026 txDest=0 writes x3 -> dropCnt=3, no l2rWr; rst asserted mid-TX_SEND -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ptr_noc_pkg.sv
// -----------------------------------------------------------------------------
// ptr_noc_pkg
// Shared definitions for the ring-NoC local network interface:
//   - default payload width, ring node count and FIFO depth
//   - default hop-count width derived from the node count
//   - TX injector state encoding
//   - saturating 16-bit increment used by event counters
// -----------------------------------------------------------------------------
package ptr_noc_pkg;

  localparam int DATA_WIDTH_DEF = 128;
  localparam int NODE_NUM_DEF   = 128;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int DEST_W_DEF     = $clog2(NODE_NUM_DEF);

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  // Counter that sticks at all-ones instead of wrapping to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ptr_sync_fifo.sv
// -----------------------------------------------------------------------------
// ptr_sync_fifo
// Single-clock FIFO with first-word fall-through output.
//   clk, rst : clock and synchronous active-high reset
//   push, din: write request and data; ignored while full, even if a pop
//              happens on the same edge
//   pop      : read request; ignored while empty
//   full     : no free entry
//   empty    : no valid entry
//   dout     : current head entry (valid when !empty)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module ptr_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == COUNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only observable once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ptr_local_ni.sv
// -----------------------------------------------------------------------------
// ptr_local_ni
// Local network interface between a host and its ring router port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// TX_IDLE | output register empty, l2rWr low, waiting for a queued flit
// TX_SEND | flit held on l2rDat/destCnt with l2rWr high until l2rRdy
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   txVld/txRdy      : host injection handshake; txRdy = TX FIFO not full
//   txDat/txDest     : host payload and hop count; txDest==0 is dropped
//   l2rWr/l2rRdy     : flit offered to router / router accepts
//   l2rDat/destCnt   : registered payload and hop count to router
//   r2lVld/r2lRd     : router flit available / NI consumes it
//   r2lDat           : router payload
//   rxVld/rxRdy      : RX FIFO head available / host pops it
//   rxDat            : RX FIFO head (fall-through)
//   dropCnt          : saturating count of flits dropped for txDest==0
// -----------------------------------------------------------------------------
module ptr_local_ni
  import ptr_noc_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int NODE_NUM   = NODE_NUM_DEF,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int DEST_W     = $clog2(NODE_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  // host TX
  input  logic                  txVld,
  output logic                  txRdy,
  input  logic [DATA_WIDTH-1:0] txDat,
  input  logic [DEST_W-1:0]     txDest,
  // router local input
  output logic                  l2rWr,
  input  logic                  l2rRdy,
  output logic [DATA_WIDTH-1:0] l2rDat,
  output logic [DEST_W-1:0]     destCnt,
  // router local output
  input  logic                  r2lVld,
  output logic                  r2lRd,
  input  logic [DATA_WIDTH-1:0] r2lDat,
  // host RX
  output logic                  rxVld,
  input  logic                  rxRdy,
  output logic [DATA_WIDTH-1:0] rxDat,
  // status
  output logic [15:0]           dropCnt
);

  localparam int TXW = DATA_WIDTH + DEST_W;

  // ---------------------------------------------------------------------------
  // TX path: host -> TX FIFO
  // ---------------------------------------------------------------------------
  logic           tx_full;
  logic           tx_empty;
  logic           tx_wr;
  logic           tx_push;
  logic           tx_drop;
  logic           tx_pop;
  logic [TXW-1:0] tx_head;

  assign txRdy   = !tx_full;
  assign tx_wr   = txVld && txRdy;
  // A zero hop count has nowhere to go on the ring; count it and discard.
  assign tx_drop = tx_wr && (txDest == '0);
  assign tx_push = tx_wr && (txDest != '0);

  ptr_sync_fifo #(
    .WIDTH (TXW),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   ({txDest, txDat}),
    .pop   (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .dout  (tx_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dropCnt <= '0;
    end else if (tx_drop) begin
      dropCnt <= sat_inc16(dropCnt);
    end
  end

  // ---------------------------------------------------------------------------
  // TX injector FSM: TX FIFO -> output register -> router
  // ---------------------------------------------------------------------------
  tx_state_e state_q;
  tx_state_e state_d;
  logic      load_out;
  logic      clear_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_pop   = 1'b0;
    load_out = 1'b0;
    clear_wr = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          load_out = 1'b1;
          state_d  = TX_SEND;
        end
      end
      TX_SEND: begin
        // Refill the output register on the transfer edge so a queued
        // stream leaves at one flit per cycle.
        if (l2rRdy) begin
          if (!tx_empty) begin
            tx_pop   = 1'b1;
            load_out = 1'b1;
          end else begin
            clear_wr = 1'b1;
            state_d  = TX_IDLE;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l2rWr   <= 1'b0;
      l2rDat  <= '0;
      destCnt <= '0;
    end else if (load_out) begin
      l2rWr   <= 1'b1;
      l2rDat  <= tx_head[DATA_WIDTH-1:0];
      destCnt <= tx_head[TXW-1:DATA_WIDTH];
    end else if (clear_wr) begin
      l2rWr   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // RX path: router -> RX FIFO -> host
  // ---------------------------------------------------------------------------
  logic rx_full;
  logic rx_empty;
  logic rx_pop;

  // Full blocks the router even when the host pops on the same edge, so
  // r2lRd never depends on rxRdy.
  assign r2lRd  = r2lVld && !rx_full;
  assign rxVld  = !rx_empty;
  assign rx_pop = rxVld && rxRdy;

  ptr_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r2lRd),
    .din   (r2lDat),
    .pop   (rx_pop),
    .full  (rx_full),
    .empty (rx_empty),
    .dout  (rxDat)
  );

endmodule

// File: tb/tb_ptr_local_ni.sv
module tb_ptr_local_ni;

  localparam int DW    = 128;
  localparam int NW    = 7;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          txVld, txRdy;
  logic [DW-1:0] txDat;
  logic [NW-1:0] txDest;
  logic          l2rWr, l2rRdy;
  logic [DW-1:0] l2rDat;
  logic [NW-1:0] destCnt;
  logic          r2lVld, r2lRd;
  logic [DW-1:0] r2lDat;
  logic          rxVld, rxRdy;
  logic [DW-1:0] rxDat;
  logic [15:0]   dropCnt;

  ptr_local_ni dut (
    .clk     (clk),
    .rst     (rst),
    .txVld   (txVld),
    .txRdy   (txRdy),
    .txDat   (txDat),
    .txDest  (txDest),
    .l2rWr   (l2rWr),
    .l2rRdy  (l2rRdy),
    .l2rDat  (l2rDat),
    .destCnt (destCnt),
    .r2lVld  (r2lVld),
    .r2lRd   (r2lRd),
    .r2lDat  (r2lDat),
    .rxVld   (rxVld),
    .rxRdy   (rxRdy),
    .rxDat   (rxDat),
    .dropCnt (dropCnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: queues for the two FIFOs plus one output slot.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [DW-1:0] dat;
    logic [NW-1:0] dest;
  } flit_t;

  flit_t         m_txq[$];
  logic [DW-1:0] m_rxq[$];
  logic          m_wr   = 1'b0;
  logic [DW-1:0] m_dat  = '0;
  logic [NW-1:0] m_dest = '0;
  int unsigned   m_drop = 0;

  always @(posedge clk) begin
    bit    acc, rd, rpop;
    flit_t f;
    if (rst) begin
      m_txq.delete();
      m_rxq.delete();
      m_wr   = 1'b0;
      m_dat  = '0;
      m_dest = '0;
      m_drop = 0;
    end else begin
      acc  = txVld && (m_txq.size() < DEPTH);
      rd   = r2lVld && (m_rxq.size() < DEPTH);
      rpop = (m_rxq.size() > 0) && rxRdy;
      if (!m_wr || l2rRdy) begin
        if (m_txq.size() > 0) begin
          f      = m_txq.pop_front();
          m_wr   = 1'b1;
          m_dat  = f.dat;
          m_dest = f.dest;
        end else begin
          m_wr = 1'b0;
        end
      end
      if (acc) begin
        if (txDest == '0) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          f.dat  = txDat;
          f.dest = txDest;
          m_txq.push_back(f);
        end
      end
      if (rpop) void'(m_rxq.pop_front());
      if (rd) m_rxq.push_back(r2lDat);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_txRdy",   txRdy,   (m_txq.size() < DEPTH));
      chk("m_l2rWr",   l2rWr,   m_wr);
      chk("m_l2rDat",  l2rDat,  m_dat);
      chk("m_destCnt", destCnt, m_dest);
      chk("m_r2lRd",   r2lRd,   r2lVld && (m_rxq.size() < DEPTH));
      chk("m_rxVld",   rxVld,   (m_rxq.size() > 0));
      if (m_rxq.size() > 0) chk("m_rxDat", rxDat, m_rxq[0]);
      chk("m_dropCnt", dropCnt, m_drop);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  logic          wr_obs  [7];
  logic [DW-1:0] dat_obs [7];
  logic [NW-1:0] dst_obs [7];
  logic          rd_obs  [6];
  logic [6:0]    exp_wr;
  logic [5:0]    exp_rd;
  int            sent;
  int            got;

  initial begin
    rst = 1'b1; txVld = 1'b0; txDat = '0; txDest = '0;
    l2rRdy = 1'b0; r2lVld = 1'b0; r2lDat = '0; rxRdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_l2rWr",   l2rWr,   0);
    chk("rst_l2rDat",  l2rDat,  0);
    chk("rst_destCnt", destCnt, 0);
    chk("rst_txRdy",   txRdy,   1);
    chk("rst_rxVld",   rxVld,   0);
    chk("rst_dropCnt", dropCnt, 0);

    // Three flits back to back: l2rWr high in cycles 2..4.
    l2rRdy = 1'b1;
    for (int c = 0; c < 7; c++) begin
      wr_obs[c]  = l2rWr;
      dat_obs[c] = l2rDat;
      dst_obs[c] = destCnt;
      if (c < 3) begin
        txVld = 1'b1; txDat = DW'('hA + c); txDest = NW'(c + 1);
      end else begin
        txVld = 1'b0;
      end
      tick();
    end
    exp_wr = 7'b0011100;
    for (int c = 0; c < 7; c++) chk("b2b_wr", wr_obs[c], exp_wr[c]);
    for (int c = 2; c < 5; c++) begin
      chk("b2b_dat",  dat_obs[c], DW'('hA + c - 2));
      chk("b2b_dest", dst_obs[c], NW'(c - 1));
    end

    // Router stall: output held stable for 5 cycles, then one transfer.
    l2rRdy = 1'b0;
    txVld = 1'b1; txDat = 'h55; txDest = 5;
    tick();
    txVld = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_wr",   l2rWr,   1);
      chk("stall_dat",  l2rDat,  'h55);
      chk("stall_dest", destCnt, 5);
      tick();
    end
    l2rRdy = 1'b1;
    chk("stall_wr_final", l2rWr, 1);
    tick();
    chk("single_xfer", l2rWr, 0);

    // Fill: 1 flit in the output register + 4 in the FIFO.
    l2rRdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      txVld = 1'b1; txDat = DW'('h10 + i); txDest = NW'(i + 1);
      tick();
    end
    txVld = 1'b0;
    chk("full_txRdy", txRdy, 0);
    chk("full_head",  l2rDat, 'h10);
    txVld = 1'b1; txDat = 'hEE; txDest = 7;   // offered while full: not taken
    tick();
    txVld = 1'b0;
    l2rRdy = 1'b1;
    tick();
    l2rRdy = 1'b0;
    chk("full_release_txRdy", txRdy, 1);
    chk("full_next_head",     l2rDat, 'h11);
    l2rRdy = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("full_drained", l2rWr, 0);
    chk("full_last",    l2rDat, 'h14);

    // RX backpressure: 6 router flits, host not popping.
    l2rRdy = 1'b0;
    rxRdy  = 1'b0;
    sent   = 0;
    for (int k = 0; k < 6; k++) begin
      r2lVld = (sent < 6);
      r2lDat = DW'('h100 + sent);
      #1;
      rd_obs[k] = r2lRd;
      if (r2lRd) sent++;
      tick();
    end
    exp_rd = 6'b001111;
    for (int k = 0; k < 6; k++) chk("rx_bp_rd", rd_obs[k], exp_rd[k]);
    rxRdy = 1'b1;
    got   = 0;
    for (int k = 0; k < 40 && got < 6; k++) begin
      r2lVld = (sent < 6);
      r2lDat = DW'('h100 + sent);
      #1;
      if (r2lRd) sent++;
      if (rxVld) begin
        chk("rx_order", rxDat, DW'('h100 + got));
        got++;
      end
      tick();
    end
    chk("rx_count", got, 6);
    r2lVld = 1'b0;
    rxRdy  = 1'b0;

    // Zero hop count is dropped.
    l2rRdy = 1'b1;
    txDest = 0;
    for (int i = 0; i < 3; i++) begin
      txVld = 1'b1; txDat = DW'('hD0 + i);
      tick();
    end
    txVld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drop_no_wr", l2rWr, 0);
      tick();
    end
    chk("drop_cnt", dropCnt, 3);

    // Reset while a flit is in flight and RX holds data.
    l2rRdy = 1'b0;
    txVld = 1'b1; txDat = 'h31; txDest = 2;
    r2lVld = 1'b1; r2lDat = 'h200;
    tick();
    txDat = 'h32; txDest = 3;
    tick();
    txVld = 1'b0;
    chk("pre_rst_wr",   l2rWr, 1);
    chk("pre_rst_rxVld", rxVld, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_wr",      l2rWr,   0);
    chk("post_rst_dat",     l2rDat,  0);
    chk("post_rst_dest",    destCnt, 0);
    chk("post_rst_drop",    dropCnt, 0);
    chk("post_rst_txRdy",   txRdy,   1);
    chk("post_rst_rxVld",   rxVld,   0);
    chk("post_rst_r2lRd",   r2lRd,   1);
    r2lVld = 1'b0;
    tick();
    tick();
    chk("post_rst_idle", l2rWr, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
